regfile_host_port: RTL and testbench

Command-driven initiator for the picoMIPS register file: accepts read, write and clear commands from a host/debug source over a valid/ready handshake. It drives the register file's write enable, write data and the two address ports, and returns read data over a second valid/ready handshake. It sits between the debug link and the register file write/read port mux, giving the host full visibility and control of the GPRs while the core is halted.

---
 rtl/regfile_host_pkg.sv | 29 ++
 rtl/regfile_host_port.sv | 153 +++++++++++++++
 tb/tb_regfile_host_port.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_host_pkg.sv
// Shared types for the picoMIPS register-file host port.
// REGFILE_HOST_CLEAR_EN adds the SWEEP state used by the CLEAR command.
package regfile_host_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

`ifdef REGFILE_HOST_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_RESP  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_RESP  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/regfile_host_port.sv
// Host/debug initiator for the picoMIPS register file: READ, WRITE and CLEAR commands.
// Define REGFILE_HOST_CLEAR_EN to build the CLEAR sweep; otherwise op 2 is rejected.
module regfile_host_port
  import regfile_host_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
  input  logic [BUS_WIDTH-1:0]  cmd_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BUS_WIDTH-1:0]  resp_data_a,
  output logic [BUS_WIDTH-1:0]  resp_data_b,
  output logic                  resp_err,
  output logic                  rf_we,
  output logic [BUS_WIDTH-1:0]  rf_wr_data,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  output logic [ADDR_WIDTH-1:0] rf_rs_addr,
  input  logic [BUS_WIDTH-1:0]  rf_rd_data,
  input  logic [BUS_WIDTH-1:0]  rf_rs_data
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  state_e                state_q;
  op_e                   op_q;
  op_e                   cmd_op_d;
  logic                  rf_we_q;
  logic [BUS_WIDTH-1:0]  rf_wr_data_q;
  logic [ADDR_WIDTH-1:0] rf_rd_addr_q;
  logic [ADDR_WIDTH-1:0] rf_rs_addr_q;
  logic [BUS_WIDTH-1:0]  resp_data_a_q;
  logic [BUS_WIDTH-1:0]  resp_data_b_q;
  logic                  resp_err_q;

  assign cmd_op_d = op_e'(cmd_op);

`ifdef REGFILE_HOST_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] sweep_cnt_q;
  logic [ADDR_WIDTH-1:0] sweep_cnt_d;

  assign sweep_cnt_d = sweep_cnt_q + ADDR_WIDTH'(1);
`endif

  // Handshake flags come straight from registered state, so no input reaches an output.
  assign cmd_ready   = (state_q == ST_IDLE);
  assign resp_valid  = (state_q == ST_RESP);
  assign resp_data_a = resp_data_a_q;
  assign resp_data_b = resp_data_b_q;
  assign resp_err    = resp_err_q;
  assign rf_we       = rf_we_q;
  assign rf_wr_data  = rf_wr_data_q;
  assign rf_rd_addr  = rf_rd_addr_q;
  assign rf_rs_addr  = rf_rs_addr_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      rf_we_q       <= 1'b0;
      rf_wr_data_q  <= '0;
      rf_rd_addr_q  <= '0;
      rf_rs_addr_q  <= '0;
      resp_data_a_q <= '0;
      resp_data_b_q <= '0;
      resp_err_q    <= 1'b0;
`ifdef REGFILE_HOST_CLEAR_EN
      sweep_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q         <= cmd_op_d;
            rf_rd_addr_q <= cmd_addr_a;
            rf_rs_addr_q <= cmd_addr_b;
            rf_wr_data_q <= cmd_data;
            case (cmd_op_d)
              OP_READ: begin
                state_q <= ST_EXEC;
              end
              OP_WRITE: begin
                // Register 0 is hard-wired zero; such writes are dropped without error.
                state_q <= ST_EXEC;
                rf_we_q <= (cmd_addr_a != ZERO_ADDR);
              end
`ifdef REGFILE_HOST_CLEAR_EN
              OP_CLEAR: begin
                state_q      <= ST_SWEEP;
                sweep_cnt_q  <= FIRST_ADDR;
                rf_rd_addr_q <= FIRST_ADDR;
                rf_wr_data_q <= '0;
                rf_we_q      <= 1'b1;
              end
`endif
              default: begin
                state_q    <= ST_RESP;
                resp_err_q <= 1'b1;
              end
            endcase
          end
        end

        ST_EXEC: begin
          rf_we_q <= 1'b0;
          if (op_q == OP_READ) begin
            resp_data_a_q <= rf_rd_data;
            resp_data_b_q <= rf_rs_data;
          end
          state_q <= ST_RESP;
        end

`ifdef REGFILE_HOST_CLEAR_EN
        ST_SWEEP: begin
          // The address output tracks the counter; the last register ends the sweep.
          if (sweep_cnt_q == LAST_ADDR) begin
            rf_we_q <= 1'b0;
            state_q <= ST_RESP;
          end else begin
            sweep_cnt_q  <= sweep_cnt_d;
            rf_rd_addr_q <= sweep_cnt_d;
          end
        end
`endif

        ST_RESP: begin
          if (resp_ready) begin
            state_q       <= ST_IDLE;
            resp_data_a_q <= '0;
            resp_data_b_q <= '0;
            resp_err_q    <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          rf_we_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_host_port.sv
// Scoreboard bench for regfile_host_port with a behavioural register file model.
// Expectations for op 2 follow REGFILE_HOST_CLEAR_EN.
module tb_regfile_host_port;

  localparam int BW = 8;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  typedef struct {
    logic [BW-1:0] dataA;
    logic [BW-1:0] dataB;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr_a;
  logic [AW-1:0] cmd_addr_b;
  logic [BW-1:0] cmd_data;
  logic          resp_valid;
  logic          resp_ready;
  logic [BW-1:0] resp_data_a;
  logic [BW-1:0] resp_data_b;
  logic          resp_err;
  logic          rf_we;
  logic [BW-1:0] rf_wr_data;
  logic [AW-1:0] rf_rd_addr;
  logic [AW-1:0] rf_rs_addr;
  logic [BW-1:0] rf_rd_data;
  logic [BW-1:0] rf_rs_data;

  logic [BW-1:0] regs [N];
  logic          modelClr;

  exp_t          expQ [$];
  logic [AW-1:0] weAddrQ [$];
  int            weCount;
  int            testsRun;
  int            testsFailed;

  always #5 clk = ~clk;

  regfile_host_port #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr_a (cmd_addr_a),
    .cmd_addr_b (cmd_addr_b),
    .cmd_data   (cmd_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data_a(resp_data_a),
    .resp_data_b(resp_data_b),
    .resp_err   (resp_err),
    .rf_we      (rf_we),
    .rf_wr_data (rf_wr_data),
    .rf_rd_addr (rf_rd_addr),
    .rf_rs_addr (rf_rs_addr),
    .rf_rd_data (rf_rd_data),
    .rf_rs_data (rf_rs_data)
  );

  // Register file model: storage survives the port's reset so partial sweeps stay visible.
  always @(posedge clk) begin
    if (modelClr) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[rf_rd_addr] <= rf_wr_data;
    end
  end

  assign rf_rd_data = regs[rf_rd_addr];
  assign rf_rs_data = regs[rf_rs_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (n_reset && resp_valid && resp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("resp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("resp_data_a", 32'(resp_data_a), 32'(e.dataA));
        checkOutput("resp_data_b", 32'(resp_data_b), 32'(e.dataB));
        checkOutput("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (n_reset && rf_we) begin
      weCount++;
      weAddrQ.push_back(rf_rd_addr);
    end
  end

  function automatic logic [BW-1:0] preVal(input int i);
    return BW'(i * 7 + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and returns one step after its handshake edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                               input logic [BW-1:0] d, input logic [BW-1:0] ea,
                               input logic [BW-1:0] eb, input logic eerr);
    int n = 0;
    expQ.push_back('{dataA: ea, dataB: eb, err: eerr});
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr_a = a;
    cmd_addr_b = b;
    cmd_data   = d;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() != 0 || !cmd_ready) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("idle_timeout", 32'(n < 200), 32'd1);
  endtask

  task automatic preloadAll();
    for (int i = 1; i < N; i++) begin
      applyStimulus(2'd1, AW'(i), '0, preVal(i), '0, '0, 1'b0);
      waitIdle();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    checkOutput({tag, "_resp_data"}, 32'({resp_data_a, resp_data_b}), 32'd0);
    checkOutput({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    checkOutput({tag, "_rf_wr_data"}, 32'(rf_wr_data), 32'd0);
    checkOutput({tag, "_rf_addrs"}, 32'({rf_rd_addr, rf_rs_addr}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cyc;
    logic seqOk;
    testsRun    = 0;
    testsFailed = 0;
    weCount     = 0;
    n_reset     = 1'b0;
    modelClr    = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_addr_a  = '0;
    cmd_addr_b  = '0;
    cmd_data    = '0;
    resp_ready  = 1'b1;
    repeat (3) tick();
    checkResetOutputs("reset");
    n_reset  = 1'b1;
    modelClr = 1'b0;
    tick();

    // Single write: one rf_we cycle, response on the following cycle.
    weCount = 0;
    applyStimulus(2'd1, 5'd5, 5'd0, 8'hA5, 8'h00, 8'h00, 1'b0);
    checkOutput("wr_rf_we_e0", 32'(rf_we), 32'd1);
    checkOutput("wr_rf_rd_addr", 32'(rf_rd_addr), 32'd5);
    checkOutput("wr_rf_wr_data", 32'(rf_wr_data), 32'hA5);
    checkOutput("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    checkOutput("wr_resp_valid_e0", 32'(resp_valid), 32'd0);
    tick();
    checkOutput("wr_rf_we_e1", 32'(rf_we), 32'd0);
    checkOutput("wr_resp_valid_e1", 32'(resp_valid), 32'd1);
    tick();
    checkOutput("wr_resp_one_cycle", 32'(resp_valid), 32'd0);
    checkOutput("wr_cmd_ready_back", 32'(cmd_ready), 32'd1);
    checkOutput("wr_we_count", 32'(weCount), 32'd1);
    checkOutput("wr_reg5", 32'(regs[5]), 32'hA5);

    applyStimulus(2'd1, 5'd9, 5'd0, 8'h3C, 8'h00, 8'h00, 1'b0);
    waitIdle();
    applyStimulus(2'd0, 5'd5, 5'd9, 8'h00, 8'hA5, 8'h3C, 1'b0);
    waitIdle();
    applyStimulus(2'd0, 5'd9, 5'd5, 8'h00, 8'h3C, 8'hA5, 1'b0);
    waitIdle();

    // Writes to register 0 are silently dropped.
    weCount = 0;
    applyStimulus(2'd1, 5'd0, 5'd0, 8'hFF, 8'h00, 8'h00, 1'b0);
    waitIdle();
    checkOutput("wr0_no_we", 32'(weCount), 32'd0);
    applyStimulus(2'd0, 5'd0, 5'd5, 8'h00, 8'h00, 8'hA5, 1'b0);
    waitIdle();

    // Reserved op with the host stalling the response for four cycles.
    weCount    = 0;
    resp_ready = 1'b0;
    applyStimulus(2'd3, 5'd7, 5'd3, 8'h55, 8'h00, 8'h00, 1'b1);
    checkOutput("rsvd_resp_valid_e0", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rsvd_hold_valid", 32'(resp_valid), 32'd1);
      checkOutput("rsvd_hold_resp", 32'({resp_err, resp_data_a, resp_data_b}), 32'h10000);
      checkOutput("rsvd_hold_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("rsvd_hold_rf_we", 32'(rf_we), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    waitIdle();
    checkOutput("rsvd_no_we", 32'(weCount), 32'd0);
    checkOutput("rsvd_err_cleared", 32'(resp_err), 32'd0);

    preloadAll();
    applyStimulus(2'd0, 5'd17, 5'd31, 8'h00, preVal(17), preVal(31), 1'b0);
    waitIdle();

`ifdef REGFILE_HOST_CLEAR_EN
    // Full sweep: 31 consecutive writes to addresses 1..31.
    weCount = 0;
    weAddrQ.delete();
    applyStimulus(2'd2, 5'd0, 5'd0, 8'h77, 8'h00, 8'h00, 1'b0);
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    checkOutput("clr_cycles", 32'(cyc), 32'(N - 1));
    waitIdle();
    checkOutput("clr_we_count", 32'(weCount), 32'(N - 1));
    seqOk = (weAddrQ.size() == N - 1);
    for (int i = 0; i < weAddrQ.size(); i++) if (weAddrQ[i] != AW'(i + 1)) seqOk = 1'b0;
    checkOutput("clr_addr_seq", 32'(seqOk), 32'd1);
    applyStimulus(2'd0, 5'd1, 5'd31, 8'h00, 8'h00, 8'h00, 1'b0);
    waitIdle();
    applyStimulus(2'd0, 5'd17, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    waitIdle();

    // Reset lands while the counter points at register 12.
    preloadAll();
    applyStimulus(2'd2, 5'd0, 5'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (11) tick();
    checkOutput("clr_mid_addr", 32'(rf_rd_addr), 32'd12);
    checkOutput("clr_mid_we", 32'(rf_we), 32'd1);
    n_reset = 1'b0;
    #1;
    expQ.delete();
    checkResetOutputs("midrst");
    repeat (2) tick();
    n_reset = 1'b1;
    tick();
    applyStimulus(2'd0, 5'd11, 5'd12, 8'h00, 8'h00, preVal(12), 1'b0);
    waitIdle();
    applyStimulus(2'd0, 5'd1, 5'd31, 8'h00, 8'h00, preVal(31), 1'b0);
    waitIdle();
`else
    // Without the sweep, op 2 is rejected and nothing is touched.
    weCount = 0;
    applyStimulus(2'd2, 5'd0, 5'd0, 8'h77, 8'h00, 8'h00, 1'b1);
    checkOutput("clr_off_resp_valid_e0", 32'(resp_valid), 32'd1);
    waitIdle();
    checkOutput("clr_off_no_we", 32'(weCount), 32'd0);
    applyStimulus(2'd0, 5'd1, 5'd31, 8'h00, preVal(1), preVal(31), 1'b0);
    waitIdle();
    cyc   = 0;
    seqOk = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
